// File: rtl/sp_pkg.sv
// Shared types and constants for the shift-pipe operand fetch stage.
package sp_pkg;

  localparam int XLEN = 3;
  localparam int NREG = 8;
  localparam int IMMW = 6;
  localparam int AW   = $clog2(NREG);

  typedef enum logic [1:0] {
    SLL  = 2'd0,
    SLR  = 2'd1,
    SLLI = 2'd2,
    SLRI = 2'd3
  } func_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  typedef struct packed {
    func_t            op;
    logic [AW-1:0]    rs1;
    logic [AW-1:0]    rs2;
    logic [AW-1:0]    rd;
    logic             imm;
    logic [XLEN-1:0]  rs1_d;
    logic [IMMW-1:0]  d2;
  } of_entry_t;

  function automatic logic is_imm(func_t op);
    return (op == SLLI) || (op == SLRI);
  endfunction

  function automatic logic [IMMW-1:0] zext(logic [XLEN-1:0] v);
    return {{(IMMW-XLEN){1'b0}}, v};
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Decode, write-back and execute links of the operand fetch stage.
// master = surrounding pipeline (decode/execute side), slave = operand_fetch.
interface operand_fetch_if;
  import sp_pkg::*;

  logic               dec_valid_i;
  logic               dec_ready_o;
  func_t              dec_opcode_i;
  logic [AW-1:0]      dec_rs1_i;
  logic [AW-1:0]      dec_rs2_i;
  logic [AW-1:0]      dec_rd_i;
  logic [IMMW-1:0]    dec_imm_i;

  logic               wb_en_i;
  logic [AW-1:0]      wb_rd_i;
  logic [XLEN-1:0]    wb_data_i;

  logic               ex_valid_o;
  logic               ex_ready_i;
  func_t              ex_opcode_o;
  logic [XLEN-1:0]    ex_rs1_data_o;
  logic [IMMW-1:0]    ex_data2_o;
  logic [AW-1:0]      ex_rd_o;

  modport master (
    output dec_valid_i, dec_opcode_i, dec_rs1_i, dec_rs2_i, dec_rd_i, dec_imm_i,
    output wb_en_i, wb_rd_i, wb_data_i, ex_ready_i,
    input  dec_ready_o, ex_valid_o, ex_opcode_o, ex_rs1_data_o, ex_data2_o, ex_rd_o
  );

  modport slave (
    input  dec_valid_i, dec_opcode_i, dec_rs1_i, dec_rs2_i, dec_rd_i, dec_imm_i,
    input  wb_en_i, wb_rd_i, wb_data_i, ex_ready_i,
    output dec_ready_o, ex_valid_o, ex_opcode_o, ex_rs1_data_o, ex_data2_o, ex_rd_o
  );

endinterface

// File: rtl/sp_regfile.sv
// Architectural register file: two async read ports with write-back bypass, r0 hardwired to 0.
module sp_regfile
  import sp_pkg::*;
(
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [XLEN-1:0]  wd,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [XLEN-1:0]  rd1,
  output logic [XLEN-1:0]  rd2
);

  logic [XLEN-1:0] regs [NREG];

  // regs[0] is never written, so it stays at its reset value of 0
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (we && (wa == ra1) && (ra1 != '0)) ? wd : regs[ra1];
  assign rd2 = (we && (wa == ra2) && (ra2 != '0)) ? wd : regs[ra2];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: register read, data2 formation and 2-entry skid buffer toward execute.
//  state | meaning
//  EMPTY | no op held, ex_valid_o low
//  ONE   | MAIN holds the op presented to execute
//  TWO   | MAIN presented, SKID holds overflow op, decode stalled
module operand_fetch
  import sp_pkg::*;
(
  input  logic           clk_i,
  input  logic           arst_ni,
  operand_fetch_if.slave bus
);

  buf_state_t      state_q, state_d;
  of_entry_t       main_q, main_d, skid_q, skid_d;
  of_entry_t       main_p, skid_p, new_e;
  logic [XLEN-1:0] rs1_rd, rs2_rd;
  logic            dec_ready, ex_valid, take_in, take_out;

  sp_regfile u_rf (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .we      (bus.wb_en_i),
    .wa      (bus.wb_rd_i),
    .wd      (bus.wb_data_i),
    .ra1     (bus.dec_rs1_i),
    .ra2     (bus.dec_rs2_i),
    .rd1     (rs1_rd),
    .rd2     (rs2_rd)
  );

  // Refresh a held entry's operands with a write-back landing this edge
  function automatic of_entry_t patch(of_entry_t e, logic en, logic [AW-1:0] rd,
                                      logic [XLEN-1:0] d);
    of_entry_t r;
    r = e;
    if (en && (rd != '0)) begin
      if (e.rs1 == rd) r.rs1_d = d;
      if (!e.imm && (e.rs2 == rd)) r.d2 = zext(d);
    end
    return r;
  endfunction

  always_comb begin
    new_e       = '0;
    new_e.op    = bus.dec_opcode_i;
    new_e.rs1   = bus.dec_rs1_i;
    new_e.rs2   = bus.dec_rs2_i;
    new_e.rd    = bus.dec_rd_i;
    new_e.imm   = is_imm(bus.dec_opcode_i);
    new_e.rs1_d = rs1_rd;
    new_e.d2    = new_e.imm ? bus.dec_imm_i : zext(rs2_rd);
  end

  assign main_p    = patch(main_q, bus.wb_en_i, bus.wb_rd_i, bus.wb_data_i);
  assign skid_p    = patch(skid_q, bus.wb_en_i, bus.wb_rd_i, bus.wb_data_i);

  assign dec_ready = (state_q != TWO);
  assign ex_valid  = (state_q != EMPTY);
  assign take_in   = bus.dec_valid_i && dec_ready;
  assign take_out  = ex_valid && bus.ex_ready_i;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_p;
    skid_d  = skid_p;
    case (state_q)
      EMPTY: begin
        if (take_in) begin
          main_d  = new_e;
          state_d = ONE;
        end
      end
      ONE: begin
        if (take_in && take_out) begin
          main_d = new_e;
        end else if (take_in) begin
          skid_d  = new_e;
          state_d = TWO;
        end else if (take_out) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (take_out) begin
          main_d  = skid_p;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign bus.dec_ready_o   = dec_ready;
  assign bus.ex_valid_o    = ex_valid;
  assign bus.ex_opcode_o   = main_q.op;
  assign bus.ex_rs1_data_o = main_q.rs1_d;
  assign bus.ex_data2_o    = main_q.d2;
  assign bus.ex_rd_o       = main_q.rd;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: vector table plus scoreboard of accepted ops.
module tb_operand_fetch;
  import sp_pkg::*;

  typedef struct {
    func_t      op;
    logic [2:0] rs1, rs2, rd;
    logic [5:0] imm;
    logic [2:0] exp_rs1;
    logic [5:0] exp_d2;
  } vec_t;

  typedef struct {
    func_t      op;
    logic [2:0] rs1, rs2, rd;
    logic       imm;
    logic [2:0] rs1_d;
    logic [5:0] d2;
  } exp_t;

  logic clk = 1'b0;
  logic arst_ni;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  logic [2:0] mregs [8];
  vec_t vt [7];

  always #5 clk = ~clk;

  operand_fetch_if bus ();
  operand_fetch dut (.clk_i(clk), .arst_ni(arst_ni), .bus(bus));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input func_t op, input logic [2:0] r1, input logic [2:0] r2,
                       input logic [2:0] rd, input logic [5:0] imm);
    bus.dec_valid_i  = 1'b1;
    bus.dec_opcode_i = op;
    bus.dec_rs1_i    = r1;
    bus.dec_rs2_i    = r2;
    bus.dec_rd_i     = rd;
    bus.dec_imm_i    = imm;
  endtask

  task automatic chk_ex(input string tag, input logic v, input logic [2:0] rs1d,
                        input logic [5:0] d2);
    chk({tag, "_valid"}, bus.ex_valid_o, v);
    chk({tag, "_rs1"}, bus.ex_rs1_data_o, rs1d);
    chk({tag, "_d2"}, bus.ex_data2_o, d2);
  endtask

  task automatic model_clear();
    sbq.delete();
    for (int i = 0; i < 8; i++) mregs[i] = 3'd0;
  endtask

  function automatic logic [2:0] mread(input logic [2:0] a);
    if (a == 3'd0) return 3'd0;
    if (bus.wb_en_i && bus.wb_rd_i == a) return bus.wb_data_i;
    return mregs[a];
  endfunction

  // Scoreboard: act on what the next rising edge will do
  always @(negedge clk) begin
    exp_t e;
    exp_t n;
    if (arst_ni) begin
      if (bus.ex_valid_o && bus.ex_ready_i) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow actual=unexpected_op required=none t=%0t", $time);
        end else begin
          e = sbq.pop_front();
          chk("sb_op", bus.ex_opcode_o, e.op);
          chk("sb_rs1", bus.ex_rs1_data_o, e.rs1_d);
          chk("sb_d2", bus.ex_data2_o, e.d2);
          chk("sb_rd", bus.ex_rd_o, e.rd);
        end
      end
      if (bus.wb_en_i && bus.wb_rd_i != 3'd0) begin
        foreach (sbq[k]) begin
          if (sbq[k].rs1 == bus.wb_rd_i) sbq[k].rs1_d = bus.wb_data_i;
          if (!sbq[k].imm && sbq[k].rs2 == bus.wb_rd_i) sbq[k].d2 = {3'b000, bus.wb_data_i};
        end
      end
      if (bus.dec_valid_i && bus.dec_ready_o) begin
        n.op    = bus.dec_opcode_i;
        n.rs1   = bus.dec_rs1_i;
        n.rs2   = bus.dec_rs2_i;
        n.rd    = bus.dec_rd_i;
        n.imm   = (bus.dec_opcode_i == SLLI) || (bus.dec_opcode_i == SLRI);
        n.rs1_d = mread(bus.dec_rs1_i);
        n.d2    = n.imm ? bus.dec_imm_i : {3'b000, mread(bus.dec_rs2_i)};
        sbq.push_back(n);
      end
      if (bus.wb_en_i && bus.wb_rd_i != 3'd0) mregs[bus.wb_rd_i] = bus.wb_data_i;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] pre [8];
    pre = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd4, 3'd3, 3'd6, 3'd7};
    // expected values assume the preload above
    vt[0] = '{SLLI, 3'd3, 3'd0, 3'd1, 6'h2A, 3'd5, 6'h2A};
    vt[1] = '{SLR,  3'd1, 3'd3, 3'd2, 6'h11, 3'd1, 6'h05};
    vt[2] = '{SLL,  3'd0, 3'd7, 3'd3, 6'h00, 3'd0, 6'h07};
    vt[3] = '{SLRI, 3'd7, 3'd2, 3'd4, 6'h3F, 3'd7, 6'h3F};
    vt[4] = '{SLL,  3'd6, 3'd0, 3'd5, 6'h15, 3'd6, 6'h00};
    vt[5] = '{SLR,  3'd2, 3'd4, 3'd6, 6'h00, 3'd2, 6'h04};
    vt[6] = '{SLLI, 3'd5, 3'd6, 3'd7, 6'h00, 3'd3, 6'h00};

    model_clear();
    arst_ni = 1'b0;
    bus.dec_valid_i = 1'b0; bus.dec_opcode_i = SLL; bus.dec_rs1_i = '0;
    bus.dec_rs2_i = '0; bus.dec_rd_i = '0; bus.dec_imm_i = '0;
    bus.wb_en_i = 1'b0; bus.wb_rd_i = '0; bus.wb_data_i = '0;
    bus.ex_ready_i = 1'b1;
    #3;
    chk_ex("rst", 1'b0, 3'd0, 6'd0);
    chk("rst_ready", bus.dec_ready_o, 1'b1);
    chk("rst_op", bus.ex_opcode_o, SLL);
    chk("rst_rd", bus.ex_rd_o, 3'd0);
    @(posedge clk); #1;
    arst_ni = 1'b1;

    for (int i = 1; i < 8; i++) begin
      bus.wb_en_i = 1'b1; bus.wb_rd_i = 3'(i); bus.wb_data_i = pre[i];
      cyc();
    end
    bus.wb_en_i = 1'b0;

    // write-back then plain read
    drive(SLL, 3'd3, 3'd0, 3'd1, 6'h00);
    cyc();
    bus.dec_valid_i = 1'b0;
    chk_ex("t1", 1'b1, 3'd5, 6'd0);
    cyc();
    chk("t1_drain", bus.ex_valid_o, 1'b0);

    for (int i = 0; i < 7; i++) begin
      drive(vt[i].op, vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].imm);
      cyc();
      chk_ex($sformatf("vec%0d", i), 1'b1, vt[i].exp_rs1, vt[i].exp_d2);
      chk($sformatf("vec%0d_rd", i), bus.ex_rd_o, vt[i].rd);
      chk($sformatf("vec%0d_op", i), bus.ex_opcode_o, vt[i].op);
    end
    bus.dec_valid_i = 1'b0;
    cyc();

    // fill both entries under backpressure, then drain in order
    bus.ex_ready_i = 1'b0;
    drive(SLL, 3'd1, 3'd2, 3'd3, 6'h00);
    cyc();
    chk("t3_ready1", bus.dec_ready_o, 1'b1);
    drive(SLR, 3'd4, 3'd6, 3'd5, 6'h00);
    cyc();
    chk("t3_ready2", bus.dec_ready_o, 1'b0);
    chk_ex("t3_hold", 1'b1, 3'd1, 6'd2);
    drive(SLLI, 3'd7, 3'd0, 3'd6, 6'h15);
    cyc();
    chk("t3_ready3", bus.dec_ready_o, 1'b0);
    chk_ex("t3_stall", 1'b1, 3'd1, 6'd2);
    bus.ex_ready_i = 1'b1;
    cyc();
    chk_ex("t3_b", 1'b1, 3'd4, 6'd6);
    chk("t3_ready4", bus.dec_ready_o, 1'b1);
    cyc();
    bus.dec_valid_i = 1'b0;
    chk_ex("t3_c", 1'b1, 3'd7, 6'h15);
    cyc();
    chk("t3_empty", bus.ex_valid_o, 1'b0);

    // write-back patches stalled MAIN and an entry moving from SKID
    bus.ex_ready_i = 1'b0;
    drive(SLL, 3'd2, 3'd0, 3'd1, 6'h00);
    cyc();
    bus.dec_valid_i = 1'b0;
    chk_ex("t4_a", 1'b1, 3'd2, 6'd0);
    bus.wb_en_i = 1'b1; bus.wb_rd_i = 3'd2; bus.wb_data_i = 3'd7;
    cyc();
    bus.wb_en_i = 1'b0;
    chk_ex("t4_patch", 1'b1, 3'd7, 6'd0);
    bus.wb_en_i = 1'b1; bus.wb_rd_i = 3'd0; bus.wb_data_i = 3'd7;
    cyc();
    bus.wb_en_i = 1'b0;
    chk_ex("t4_r0", 1'b1, 3'd7, 6'd0);
    drive(SLR, 3'd0, 3'd5, 3'd4, 6'h00);
    cyc();
    bus.dec_valid_i = 1'b0;
    chk("t4_two", bus.dec_ready_o, 1'b0);
    bus.ex_ready_i = 1'b1;
    bus.wb_en_i = 1'b1; bus.wb_rd_i = 3'd5; bus.wb_data_i = 3'd1;
    cyc();
    bus.wb_en_i = 1'b0;
    chk_ex("t4_move", 1'b1, 3'd0, 6'd1);
    cyc();
    chk("t4_empty", bus.ex_valid_o, 1'b0);

    // same-cycle write-back and accept
    bus.wb_en_i = 1'b1; bus.wb_rd_i = 3'd4; bus.wb_data_i = 3'd6;
    drive(SLL, 3'd4, 3'd4, 3'd2, 6'h00);
    cyc();
    bus.wb_en_i = 1'b0;
    bus.dec_valid_i = 1'b0;
    chk_ex("t5", 1'b1, 3'd6, 6'd6);
    cyc();

    // async reset while both entries are held
    bus.ex_ready_i = 1'b0;
    drive(SLL, 3'd1, 3'd2, 3'd1, 6'h00);
    cyc();
    drive(SLR, 3'd3, 3'd4, 3'd2, 6'h00);
    cyc();
    bus.dec_valid_i = 1'b0;
    chk("t6_two", bus.dec_ready_o, 1'b0);
    #2;
    arst_ni = 1'b0;
    model_clear();
    #1;
    chk_ex("t6_rst", 1'b0, 3'd0, 6'd0);
    chk("t6_ready", bus.dec_ready_o, 1'b1);
    cyc();
    arst_ni = 1'b1;
    bus.ex_ready_i = 1'b1;
    for (int i = 1; i < 8; i++) begin
      drive(SLL, 3'(i), 3'(i), 3'(i), 6'h00);
      cyc();
      chk_ex($sformatf("t6_r%0d", i), 1'b1, 3'd0, 6'd0);
    end
    bus.dec_valid_i = 1'b0;
    cyc();
    chk("end_valid", bus.ex_valid_o, 1'b0);
    chk("sb_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
